// File: rtl/timestamp_capture_pkg.sv
// Shared defaults and sizing helpers for the timestamp capture block.
package timestamp_capture_pkg;

  localparam int CW_DEF       = 32;
  localparam int LAT_COMP_DEF = 2;

  // Level counter must represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/timestamp_capture_ts_fifo.sv
// Generic synchronous FIFO: binary pointers, separate level counter, head shown combinationally.
module ts_fifo
  import timestamp_capture_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [W-1:0]              i_data,
  output logic [W-1:0]              o_data,
  output logic [level_w(DEPTH)-1:0] o_level,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset, so the empty head is forced to zero.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/timestamp_capture.sv
// Captures the free-running count on each rising edge of an async event line and queues it.
module timestamp_capture
  import timestamp_capture_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CW       = CW_DEF,
  parameter int LAT_COMP = LAT_COMP_DEF,
  parameter int DROP_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CW-1:0]             count,
  input  logic                      evt_in,
  input  logic                      clr_ovf,
  output logic [CW-1:0]             ts_data,
  output logic                      ts_valid,
  input  logic                      ts_ready,
  output logic [level_w(DEPTH)-1:0] fifo_level,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt
);

  logic              r_s1;
  logic              r_s2;
  logic              r_prev;
  logic [1:0]        r_warm;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              w_edge;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [CW-1:0]     w_ts;

  // Edges are ignored until s2 and prev both hold real samples, so a line
  // already high at reset release does not look like a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_warm <= 2'd0;
    end else begin
      r_s1   <= evt_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  assign w_edge   = r_s2 & ~r_prev & (r_warm == 2'd3);
  assign w_ts     = count - CW'(LAT_COMP);
  assign ts_valid = ~w_empty;
  assign w_pop    = ts_valid & ts_ready;
  assign w_drop   = w_edge & w_full & ~w_pop;

  ts_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_edge),
    .i_pop   (w_pop),
    .i_data  (w_ts),
    .o_data  (ts_data),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A drop in the same cycle as a clear wins, leaving exactly one recorded drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf)                       r_drop_cnt <= DROP_W'(1);
      else if (r_drop_cnt != '1)         r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
